// File: rtl/microsequencer.sv
// Next-state engine of the microprogrammed control unit.
// Increment/jump/dispatch/branch/wait/call/return plus wait watchdog and fault report.
module microsequencer #(
  parameter int STATE_W = 7,
  parameter logic [STATE_W-1:0] FAULT_STATE = 7'd127,
  parameter int WAIT_LIMIT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         n_sel,
  input  logic [STATE_W-1:0] cr,
  input  logic [1:0]         cond_sel,
  input  logic               inv,
  input  logic               moc,
  input  logic               cond_flag,
  input  logic [STATE_W-1:0] enc_state,
  input  logic               enc_valid,
  output logic [STATE_W-1:0] current_state,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [7:0]         wait_cnt
);

  localparam logic [2:0] N_INC  = 3'd0;
  localparam logic [2:0] N_JMP  = 3'd1;
  localparam logic [2:0] N_DISP = 3'd2;
  localparam logic [2:0] N_BR   = 3'd3;
  localparam logic [2:0] N_WAIT = 3'd4;
  localparam logic [2:0] N_CALL = 3'd5;
  localparam logic [2:0] N_RET  = 3'd6;

  localparam logic [1:0] F_NONE = 2'd0;
  localparam logic [1:0] F_WAIT = 2'd1;
  localparam logic [1:0] F_ILL  = 2'd2;
  localparam logic [1:0] F_RSV  = 2'd3;

  localparam logic [8:0] LIMIT = 9'(WAIT_LIMIT);

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] ret_q, ret_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               fault_q, fault_d;
  logic [1:0]         code_q, code_d;

  logic               cond_raw;
  logic               cond;
  logic [STATE_W-1:0] incr;
  logic [8:0]         cnt_inc;
  logic [1:0]         hit;

  always_comb begin
    cond_raw = 1'b0;
    case (cond_sel)
      2'd0:    cond_raw = moc;
      2'd1:    cond_raw = cond_flag;
      2'd2:    cond_raw = 1'b1;
      default: cond_raw = 1'b0;
    endcase
    cond    = cond_raw ^ inv;
    incr    = state_q + 1'b1;
    cnt_inc = {1'b0, cnt_q} + 9'd1;
  end

  always_comb begin
    state_d = incr;
    ret_d   = ret_q;
    cnt_d   = 8'd0;
    hit     = F_NONE;
    case (n_sel)
      N_INC:  state_d = incr;
      N_JMP:  state_d = cr;
      N_DISP: begin
        if (enc_valid) begin
          state_d = enc_state;
        end else begin
          state_d = FAULT_STATE;
          hit     = F_ILL;
        end
      end
      N_BR:   state_d = cond ? cr : incr;
      N_WAIT: begin
        if (cond) begin
          state_d = incr;
        end else if (cnt_inc < LIMIT) begin
          state_d = state_q;
          cnt_d   = cnt_inc[7:0];
        end else begin
          state_d = FAULT_STATE;
          hit     = F_WAIT;
        end
      end
      N_CALL: begin
        ret_d   = incr;
        state_d = cr;
      end
      N_RET:  state_d = ret_q;
      default: begin
        state_d = FAULT_STATE;
        hit     = F_RSV;
      end
    endcase
    // first fault wins; code stays zero until one is seen
    fault_d = fault_q | (hit != F_NONE);
    code_d  = fault_q ? code_q : hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
      ret_q   <= '0;
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
      code_q  <= F_NONE;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  assign current_state = state_q;
  assign fault         = fault_q;
  assign fault_code    = code_q;
  assign wait_cnt      = cnt_q;

endmodule

// File: tb/tb_microsequencer.sv
// Bench for microsequencer: directed vector table then randomized
// stimulus against a behavioural model.
module tb_microsequencer;

  localparam int WL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] n_sel;
  logic [6:0] cr;
  logic [1:0] cond_sel;
  logic       inv, moc, cond_flag;
  logic [6:0] enc_state;
  logic       enc_valid;
  logic [6:0] current_state;
  logic       fault;
  logic [1:0] fault_code;
  logic [7:0] wait_cnt;

  microsequencer #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset), .n_sel(n_sel), .cr(cr),
    .cond_sel(cond_sel), .inv(inv), .moc(moc),
    .cond_flag(cond_flag), .enc_state(enc_state),
    .enc_valid(enc_valid), .current_state(current_state),
    .fault(fault), .fault_code(fault_code), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst, ns, cr, cs, inv, moc, cf, enc, ev;
    int e_st, e_f, e_code, e_cnt;
  } vec_t;

  vec_t tbl[$];
  int n_cmp = 0;
  int n_bad = 0;

  int m_state, m_ret, m_cnt, m_fault, m_code;

  function automatic vec_t mk(int rst, int ns, int c, int cs, int iv,
                              int mo, int cf, int enc, int ev,
                              int es, int ef, int ec, int en);
    vec_t v;
    v.rst = rst; v.ns = ns; v.cr = c; v.cs = cs; v.inv = iv;
    v.moc = mo; v.cf = cf; v.enc = enc; v.ev = ev;
    v.e_st = es; v.e_f = ef; v.e_code = ec; v.e_cnt = en;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    reset     = (v.rst != 0);
    n_sel     = 3'(v.ns);
    cr        = 7'(v.cr);
    cond_sel  = 2'(v.cs);
    inv       = (v.inv != 0);
    moc       = (v.moc != 0);
    cond_flag = (v.cf != 0);
    enc_state = 7'(v.enc);
    enc_valid = (v.ev != 0);
  endtask

  task automatic model_step(input vec_t v);
    int c, incr, nxt, ncnt, code;
    if (v.rst != 0) begin
      m_state = 0; m_ret = 0; m_cnt = 0; m_fault = 0; m_code = 0;
      return;
    end
    if (v.cs == 0)      c = v.moc;
    else if (v.cs == 1) c = v.cf;
    else if (v.cs == 2) c = 1;
    else                c = 0;
    if (v.inv != 0) c = 1 - c;
    incr = (m_state + 1) % 128;
    nxt = incr; ncnt = 0; code = 0;
    case (v.ns)
      1: nxt = v.cr;
      2: if (v.ev != 0) nxt = v.enc; else begin nxt = 127; code = 2; end
      3: nxt = (c != 0) ? v.cr : incr;
      4: begin
        if (c != 0) nxt = incr;
        else if (m_cnt + 1 < WL) begin nxt = m_state; ncnt = m_cnt + 1; end
        else begin nxt = 127; code = 1; end
      end
      5: begin m_ret = incr; nxt = v.cr; end
      6: nxt = m_ret;
      7: begin nxt = 127; code = 3; end
      default: nxt = incr;
    endcase
    if (code != 0 && m_fault == 0) begin
      m_fault = 1; m_code = code;
    end
    m_state = nxt; m_cnt = ncnt;
  endtask

  initial begin
    vec_t v;
    drive(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0));
    // reset, increment, wrap
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,    0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,    0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,    1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,    2,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,    3,0,0,0));
    tbl.push_back(mk(0,1,127,0,0,0,0,0,0,  127,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,    0,0,0,0));
    // dispatch
    tbl.push_back(mk(0,1,1,0,0,0,0,0,0,    1,0,0,0));
    tbl.push_back(mk(0,2,0,0,0,0,0,16,1,   16,0,0,0));
    // wait on moc, released before limit
    tbl.push_back(mk(0,1,9,0,0,0,0,0,0,    9,0,0,0));
    tbl.push_back(mk(0,4,0,0,0,0,0,0,0,    9,0,0,1));
    tbl.push_back(mk(0,4,0,0,0,0,0,0,0,    9,0,0,2));
    tbl.push_back(mk(0,4,0,0,0,1,0,0,0,    10,0,0,0));
    // branch
    tbl.push_back(mk(0,3,44,1,1,0,1,0,0,   11,0,0,0));
    tbl.push_back(mk(0,3,44,1,0,0,1,0,0,   44,0,0,0));
    // call / return, nested overwrite
    tbl.push_back(mk(0,1,7,0,0,0,0,0,0,    7,0,0,0));
    tbl.push_back(mk(0,5,50,0,0,0,0,0,0,   50,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,    51,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,    52,0,0,0));
    tbl.push_back(mk(0,6,0,0,0,0,0,0,0,    8,0,0,0));
    tbl.push_back(mk(0,5,20,0,0,0,0,0,0,   20,0,0,0));
    tbl.push_back(mk(0,5,30,0,0,0,0,0,0,   30,0,0,0));
    tbl.push_back(mk(0,6,0,0,0,0,0,0,0,    21,0,0,0));
    tbl.push_back(mk(0,6,0,0,0,0,0,0,0,    21,0,0,0));
    // constant conditions
    tbl.push_back(mk(0,3,5,2,0,0,0,0,0,    5,0,0,0));
    tbl.push_back(mk(0,3,9,3,0,0,0,0,0,    6,0,0,0));
    tbl.push_back(mk(0,4,0,2,0,0,0,0,0,    7,0,0,0));
    // wait timeout, then sticky code
    tbl.push_back(mk(0,1,9,0,0,0,0,0,0,    9,0,0,0));
    tbl.push_back(mk(0,4,0,0,0,0,0,0,0,    9,0,0,1));
    tbl.push_back(mk(0,4,0,0,0,0,0,0,0,    9,0,0,2));
    tbl.push_back(mk(0,4,0,0,0,0,0,0,0,    9,0,0,3));
    tbl.push_back(mk(0,4,0,0,0,0,0,0,0,    127,1,1,0));
    tbl.push_back(mk(0,7,0,0,0,0,0,0,0,    127,1,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,    0,0,0,0));
    // return without call, reserved, later faults
    tbl.push_back(mk(0,6,0,0,0,0,0,0,0,    0,0,0,0));
    tbl.push_back(mk(0,7,0,0,0,0,0,0,0,    127,1,3,0));
    tbl.push_back(mk(0,2,0,0,0,0,0,5,0,    127,1,3,0));
    tbl.push_back(mk(0,2,0,0,0,0,0,40,1,   40,1,3,0));
    tbl.push_back(mk(1,7,0,0,0,0,0,0,0,    0,0,0,0));
    // condition true exactly at the limit
    tbl.push_back(mk(0,1,9,0,0,0,0,0,0,    9,0,0,0));
    tbl.push_back(mk(0,4,0,0,0,0,0,0,0,    9,0,0,1));
    tbl.push_back(mk(0,4,0,0,0,0,0,0,0,    9,0,0,2));
    tbl.push_back(mk(0,4,0,0,0,0,0,0,0,    9,0,0,3));
    tbl.push_back(mk(0,4,0,0,0,1,0,0,0,    10,0,0,0));
    // reset mid-call/mid-wait
    tbl.push_back(mk(0,5,60,0,0,0,0,0,0,   60,0,0,0));
    tbl.push_back(mk(0,4,0,0,0,0,0,0,0,    60,0,0,1));
    tbl.push_back(mk(1,4,0,0,0,0,0,0,0,    0,0,0,0));
    tbl.push_back(mk(0,6,0,0,0,0,0,0,0,    0,0,0,0));
    tbl.push_back(mk(0,2,0,0,0,0,0,3,0,    127,1,2,0));
    // wait count clears on a non-wait cycle
    tbl.push_back(mk(0,1,9,0,0,0,0,0,0,    9,1,2,0));
    tbl.push_back(mk(0,4,0,1,0,0,0,0,0,    9,1,2,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,    10,1,2,0));
    tbl.push_back(mk(0,4,0,1,0,0,0,0,0,    10,1,2,1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      check($sformatf("vec%0d.state", i), current_state, tbl[i].e_st);
      check($sformatf("vec%0d.fault", i), fault, tbl[i].e_f);
      check($sformatf("vec%0d.code", i), fault_code, tbl[i].e_code);
      check($sformatf("vec%0d.wcnt", i), wait_cnt, tbl[i].e_cnt);
    end

    // randomized run against the model
    v = mk(1,0,0,0,0,0,0,0,0, 0,0,0,0);
    drive(v); model_step(v);
    @(posedge clk); #1;
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      v.rst = ($urandom_range(0, 79) == 0) ? 1 : 0;
      if (r < 20)      v.ns = 0;
      else if (r < 30) v.ns = 1;
      else if (r < 40) v.ns = 2;
      else if (r < 55) v.ns = 3;
      else if (r < 80) v.ns = 4;
      else if (r < 88) v.ns = 5;
      else if (r < 97) v.ns = 6;
      else             v.ns = 7;
      v.cr  = $urandom_range(0, 127);
      v.cs  = $urandom_range(0, 3);
      v.inv = $urandom_range(0, 1);
      v.moc = ($urandom_range(0, 3) == 0) ? 1 : 0;
      v.cf  = $urandom_range(0, 1);
      v.enc = $urandom_range(0, 127);
      v.ev  = ($urandom_range(0, 7) != 0) ? 1 : 0;
      drive(v);
      model_step(v);
      @(posedge clk); #1;
      check("rnd.state", current_state, m_state);
      check("rnd.fault", fault, m_fault);
      check("rnd.code", fault_code, m_code);
      check("rnd.wcnt", wait_cnt, m_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
